la_capture_ctrl: RTL and testbench

Capture controller for the logic analyzer's 2048 x 8 sample buffer. It samples an 8-bit probe bus into the buffer as a circular pre-trigger history and evaluates a masked trigger. After the trigger it fills the rest of the buffer, then stops. It then serves random-access readout of the frozen capture, indexed from the oldest sample. It sits directly upstream of the buffer RAM and drives all of that RAM's ports.

---
 rtl/la_pkg.sv | 8 +
 rtl/la_capture_ctrl_if.sv | 13 +
 rtl/la_capture_ctrl_trigger.sv | 35 +++
 rtl/la_capture_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared constants and state encoding for the logic-analyzer capture controller.
package la_pkg;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} cap_state_t;
endpackage

// File: rtl/la_capture_ctrl_if.sv
// Sample-buffer RAM port bundle; the capture controller is the master.
interface la_capture_ctrl_if;
  import la_pkg::*;

  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  modport master (output bram_en, bram_we, bram_addr, bram_din, input bram_dout);
  modport slave  (input bram_en, bram_we, bram_addr, bram_din, output bram_dout);
endinterface

// File: rtl/la_capture_ctrl_trigger.sv
// Per-sample trigger comparator: masked level match, plus edge match on
// trig_edge bits when LA_CAPTURE_EDGE_TRIG_EN is defined.
module la_trigger_match
  import la_pkg::*;
(
  input  logic [DATA_W-1:0] i_probe,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [DATA_W-1:0] i_value,
`ifdef LA_CAPTURE_EDGE_TRIG_EN
  input  logic [DATA_W-1:0] i_edge,
  input  logic [DATA_W-1:0] i_prev,
  input  logic              i_prev_valid,
`endif
  output logic              o_hit
);

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  logic [DATA_W-1:0] w_lvl_bits;
  logic [DATA_W-1:0] w_edge_bits;
  logic              w_lvl_ok;
  logic              w_edge_ok;

  assign w_lvl_bits  = i_mask & ~i_edge;
  assign w_edge_bits = i_mask & i_edge;
  assign w_lvl_ok    = ((i_probe ^ i_value) & w_lvl_bits) == '0;
  // An edge bit hits only if it now sits at the target level and the previous sample did not.
  assign w_edge_ok   = (w_edge_bits == '0) ||
                       (i_prev_valid &&
                        (((i_probe ^ i_value) & w_edge_bits) == '0) &&
                        (((i_prev ^ i_value) & w_edge_bits) == w_edge_bits));
  assign o_hit       = w_lvl_ok & w_edge_ok;
`else
  assign o_hit = ((i_probe ^ i_value) & i_mask) == '0;
`endif
endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller for the 2048 x 8 sample buffer: circular pre-trigger fill,
// masked trigger, post-trigger fill, then oldest-first readout. Option: LA_CAPTURE_EDGE_TRIG_EN.
module la_capture_ctrl
  import la_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] probe,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
`ifdef LA_CAPTURE_EDGE_TRIG_EN
  input  logic [DATA_W-1:0] trig_edge,
`endif
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  la_capture_ctrl_if.master bram
);

  cap_state_t        r_state;
  cap_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pre;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_value;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_triggered;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_start_addr;
  logic              r_bram_en;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_din;
  logic              r_rd_valid;

  logic              w_hit;
  logic              w_arm_load;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_trig_set;
  logic [ADDR_W-1:0] w_trig_start;

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  logic [DATA_W-1:0] r_edge;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
`endif

  la_trigger_match u_match (
    .i_probe      (probe),
    .i_mask       (r_mask),
    .i_value      (r_value),
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    .i_edge       (r_edge),
    .i_prev       (r_prev),
    .i_prev_valid (r_prev_valid),
`endif
    .o_hit        (w_hit)
  );

  assign w_trig_start = r_wr_ptr - r_pre;

  always_comb begin
    w_state_nxt = r_state;
    w_arm_load  = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_trig_set  = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (arm) begin
            w_arm_load  = 1'b1;
            w_state_nxt = (pre_count == '0) ? ARMED : FILL;
          end else if (r_state == DONE && rd_req) begin
            w_rd_en = 1'b1;
          end
        end
        FILL: begin
          if (sample_en) begin
            w_wr_en = 1'b1;
            // wr_ptr equals the sample index while filling, since it restarts at 0 on arm
            if (r_wr_ptr == r_pre - ADDR_W'(1)) w_state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (sample_en) begin
            w_wr_en = 1'b1;
            if (w_hit) begin
              w_trig_set  = 1'b1;
              // With a full-depth pre-trigger window the trigger sample is the only post sample
              w_state_nxt = (r_pre == '1) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (sample_en) begin
            w_wr_en = 1'b1;
            if (r_wr_ptr == r_start_addr - ADDR_W'(1)) w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_pre        <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_wr_ptr     <= '0;
      r_triggered  <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bram_en  <= w_wr_en | w_rd_en;
      r_bram_we  <= w_wr_en;
      r_rd_valid <= r_bram_en & ~r_bram_we;
      if (w_wr_en) begin
        r_bram_addr <= r_wr_ptr;
        r_bram_din  <= probe;
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
      end else if (w_rd_en) begin
        r_bram_addr <= r_start_addr + rd_idx;
      end
      if (abort) begin
        r_triggered <= 1'b0;
      end else if (w_arm_load) begin
        r_pre       <= pre_count;
        r_mask      <= trig_mask;
        r_value     <= trig_value;
        r_triggered <= 1'b0;
        r_wr_ptr    <= '0;
      end
      if (w_trig_set) begin
        r_triggered  <= 1'b1;
        r_trig_addr  <= r_wr_ptr;
        r_start_addr <= w_trig_start;
      end
    end
  end

`ifdef LA_CAPTURE_EDGE_TRIG_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_edge       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_arm_load) begin
      r_edge       <= trig_edge;
      r_prev_valid <= 1'b0;
    end else if (w_wr_en) begin
      r_prev       <= probe;
      r_prev_valid <= 1'b1;
    end
  end
`endif

  assign bram.bram_en   = r_bram_en;
  assign bram.bram_we   = r_bram_we;
  assign bram.bram_addr = r_bram_addr;
  assign bram.bram_din  = r_bram_din;
  assign rd_data        = bram.bram_dout;
  assign rd_valid       = r_rd_valid;
  assign busy           = (r_state == FILL) || (r_state == ARMED) || (r_state == POST);
  assign done           = (r_state == DONE);
  assign triggered      = r_triggered;
  assign trig_addr      = r_trig_addr;
  assign start_addr     = r_start_addr;
endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed/random bench for la_capture_ctrl with a sample-history reference model.
module tb_la_capture_ctrl;
  import la_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [DATA_W-1:0] probe = '0;
  logic              sample_en = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] pre_count = '0;
  logic [DATA_W-1:0] trig_mask = '0;
  logic [DATA_W-1:0] trig_value = '0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_idx = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, busy, triggered, done;
  logic [ADDR_W-1:0] trig_addr, start_addr;

  always #5 CLK = ~CLK;

  la_capture_ctrl_if bram ();

  la_capture_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .probe      (probe),
    .sample_en  (sample_en),
    .arm        (arm),
    .abort      (abort),
    .pre_count  (pre_count),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .rd_req     (rd_req),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr),
    .start_addr (start_addr),
    .bram       (bram)
  );

  // Buffer RAM with registered read port
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (bram.bram_en) begin
      if (bram.bram_we) mem[bram.bram_addr] <= bram.bram_din;
      else              bram.bram_dout      <= mem[bram.bram_addr];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] samples[$];
  int g_trig;
  int g_pre;
  int rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // pat 0: k mod 256; 1: random; 2: 11/22 alternating until k=2100, then 3C
  task automatic do_capture(input int pre, input logic [7:0] mask, input logic [7:0] value,
                            input int pat, input bit toggle, input bit rand_arm, input int stop_post);
    int k = 0;
    int trig = -1;
    int cyc = 0;
    bit fin = 1'b0;
    bit en;
    logic [7:0] p;
    samples.delete();
    pre_count  = ADDR_W'(pre);
    trig_mask  = mask;
    trig_value = value;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_status", {28'd0, busy, triggered, done, bram.bram_en}, 32'b1000);
    while (!fin && cyc < 20000) begin
      if (stop_post >= 0 && trig >= 0 && (k - trig) >= stop_post) break;
      en = toggle ? (cyc % 2 == 0) : 1'b1;
      case (pat)
        0:       p = 8'(k);
        1:       p = 8'($urandom);
        default: p = (k < 2100) ? ((k % 2 == 1) ? 8'h11 : 8'h22) : 8'h3C;
      endcase
      probe     = p;
      sample_en = en;
      arm       = rand_arm && ($urandom_range(0, 15) == 0);
      tick();
      cyc++;
      if (en) begin
        samples.push_back(p);
        if (trig < 0 && k >= pre && ((p ^ value) & mask) == 8'h00) trig = k;
        if (trig >= 0 && k == trig + int'(DEPTH) - pre - 1) fin = 1'b1;
        check("wr_port", {11'd0, bram.bram_en, bram.bram_we, bram.bram_addr, bram.bram_din},
              {11'd0, 1'b1, 1'b1, ADDR_W'(k % int'(DEPTH)), p});
        k++;
      end else begin
        check("no_wr_idle", {31'd0, bram.bram_en}, 32'd0);
      end
      check("status", {29'd0, busy, triggered, done}, {29'd0, !fin, trig >= 0, fin});
    end
    sample_en = 1'b0;
    arm       = 1'b0;
    if (stop_post < 0) check("capture_completed", {31'd0, fin}, 32'd1);
    if (trig >= 0) begin
      check("trig_addr", {21'd0, trig_addr}, 32'(trig % int'(DEPTH)));
      check("start_addr", {21'd0, start_addr}, 32'((trig - pre) % int'(DEPTH)));
    end
    g_trig = trig;
    g_pre  = pre;
  endtask

  task automatic read_burst();
    int n = rq.size();
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        rd_req = 1'b1;
        rd_idx = ADDR_W'(rq[c]);
      end else begin
        rd_req = 1'b0;
      end
      tick();
      if (c < n)
        check("rd_port", {19'd0, bram.bram_en, bram.bram_we, bram.bram_addr},
              {19'd0, 1'b1, 1'b0, ADDR_W'((g_trig - g_pre + rq[c]) % int'(DEPTH))});
      if (c == 0) check("rd_latency", {31'd0, rd_valid}, 32'd0);
      if (c >= 1)
        check("rd_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, samples[g_trig - g_pre + rq[c-1]]});
    end
    tick();
    check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
    rq.delete();
  endtask

  initial begin
    // reset
    tick();
    check("rst_bram", {10'd0, bram.bram_en, bram.bram_we, bram.bram_addr, bram.bram_din, rd_valid}, 32'd0);
    check("rst_stat", {7'd0, busy, triggered, done, trig_addr, start_addr}, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    check("idle_after_rst", {29'd0, busy, done, bram.bram_en}, 32'd0);

    // pre=4, exact match on A5
    do_capture(4, 8'hFF, 8'hA5, 0, 1'b0, 1'b0, -1);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    check("no_wr_done", {31'd0, bram.bram_en}, 32'd0);
    rq = '{0, 4, 2047};
    read_burst();
    rq = '{1};
    read_burst();

    // pre=0, mask=0: first sample triggers
    do_capture(0, 8'h00, 8'h5A, 1, 1'b0, 1'b0, -1);
    rq = '{0, $urandom_range(0, 2047), $urandom_range(0, 2047), 2047};
    read_burst();

    // pre=2047: early match ignored, single post sample
    do_capture(2047, 8'hFF, 8'h0A, 0, 1'b0, 1'b0, -1);
    rq = '{0, 2047, 10};
    read_burst();

    // sample_en toggling in ARMED across the 2047 -> 0 wrap
    do_capture(4, 8'hFF, 8'h3C, 2, 1'b1, 1'b0, -1);
    rq = '{0, 3, 4, 2047};
    read_burst();

    // random capture with stray arm pulses
    do_capture(int'($urandom_range(0, 2047)), 8'($urandom) & 8'h0F, 8'($urandom), 1, 1'b1, 1'b1, -1);
    for (int i = 0; i < 6; i++) rq.push_back(int'($urandom_range(0, 2047)));
    read_burst();

    // abort with simultaneous arm while in POST
    do_capture(4, 8'hFF, 8'hA5, 0, 1'b0, 1'b0, 10);
    abort     = 1'b1;
    arm       = 1'b1;
    sample_en = 1'b1;
    tick();
    abort     = 1'b0;
    arm       = 1'b0;
    sample_en = 1'b0;
    check("abort_status", {28'd0, busy, triggered, done, bram.bram_en}, 32'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("abort_rd_port", {31'd0, bram.bram_en}, 32'd0);
    tick();
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);

    // asynchronous reset mid-capture
    do_capture(8, 8'hFF, 8'h07, 0, 1'b0, 1'b0, 0);
    sample_en = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst", {28'd0, busy, triggered, done, bram.bram_en}, 32'd0);
    sample_en = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    check("post_rst_idle", {30'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
